// File: rtl/mesm6_alu_ctl_if.sv
// ============================================================================
//  Module   : mesm6_alu_ctl_if
//  Purpose  : Request/response channel between the instruction-execute unit
//             and the ALU sequencer (mesm6_alu_ctl).
//  Signals  : req_valid/req_ready handshake with req_op, req_wy, req_a, req_b;
//             flush abort; resp_valid pulse with resp_result/resp_err; busy.
//  Modports : master - execute unit side, slave - sequencer side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif

interface mesm6_alu_ctl_if #(
    parameter int OPW = `ALU_OP_WIDTH
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic           req_wy;
    logic [47:0]    req_a;
    logic [47:0]    req_b;
    logic           flush;
    logic           resp_valid;
    logic [47:0]    resp_result;
    logic           resp_err;
    logic           busy;

    modport master (
        output req_valid, req_op, req_wy, req_a, req_b, flush,
        input  req_ready, resp_valid, resp_result, resp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_wy, req_a, req_b, flush,
        output req_ready, resp_valid, resp_result, resp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/mesm6_alu_ctl.sv
// ============================================================================
//  Module   : mesm6_alu_ctl
//  Purpose  : Sequencer between the execute unit and the 48-bit ALU. Takes
//             one request at a time, drives the ALU, waits for done, returns
//             a registered result and re-arms the ALU with an ALU_NOP cycle.
//             Also sequences Y-register loads and aborts on flush.
//  Ports    : clk, reset_n (async, active low)
//             bus      - mesm6_alu_ctl_if.slave request/response channel
//             alu_op/alu_wy/alu_a/alu_b - to the ALU
//             alu_result/alu_done       - from the ALU
//  Options  : MESM6_ALU_TIMEOUT_EN - abort RUN after TIMEOUT cycles with
//             resp_err=1 (ops the ALU does not implement, e.g. FADD).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif

module mesm6_alu_ctl #(
    parameter int OPW = `ALU_OP_WIDTH
`ifdef MESM6_ALU_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 63
`endif
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mesm6_alu_ctl_if.slave   bus,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_wy,
    output logic [47:0]      alu_a,
    output logic [47:0]      alu_b,
    input  wire logic [47:0] alu_result,
    input  wire logic        alu_done
);

    localparam logic [OPW-1:0] c_alu_nop = OPW'(`ALU_NOP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADY = 3'd1,
        S_RUN   = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [OPW-1:0] r_op;
    logic [47:0]    r_a;
    logic [47:0]    r_b;
    logic [47:0]    r_resp_result;
    logic           r_resp_err;

    logic           w_accept;
    logic           w_load_resp;
    logic [47:0]    w_resp_data;
    logic           w_resp_err;
    logic           w_timeout;

`ifdef MESM6_ALU_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    logic [c_cnt_w-1:0] r_cnt;

    // The edge that would take the counter to TIMEOUT ends RUN, so RUN lasts
    // exactly TIMEOUT cycles when done never arrives.
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN && !alu_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and response-capture decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_resp = 1'b0;
        w_resp_data = '0;
        w_resp_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // flush is deliberately not looked at here
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (bus.req_op != c_alu_nop) begin
                        w_state_nxt = S_RUN;
                    end else if (bus.req_wy) begin
                        w_state_nxt = S_LOADY;
                    end else begin
                        // Plain NOP: operand A is echoed without using the ALU
                        w_state_nxt = S_RESP;
                        w_load_resp = 1'b1;
                        w_resp_data = bus.req_a;
                    end
                end
            end
            S_LOADY: begin
                // The Y write is presented this cycle whatever happens next
                if (bus.flush) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp_data = r_a;
                end
            end
            S_RUN: begin
                // flush has priority over a coincident done
                if (bus.flush) begin
                    w_state_nxt = S_DRAIN;
                end else if (alu_done) begin
                    w_state_nxt = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp_data = alu_result;
                end else if (w_timeout) begin
                    w_state_nxt = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp_err  = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched request and held response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op          <= c_alu_nop;
            r_a           <= '0;
            r_b           <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.req_op;
                r_a  <= bus.req_a;
                r_b  <= bus.req_b;
            end
            if (w_load_resp) begin
                r_resp_result <= w_resp_data;
                r_resp_err    <= w_resp_err;
            end
        end
    end

    // Everything outside RUN presents ALU_NOP, which also clears a stale
    // done in the ALU (it has no reset of its own).
    assign alu_op  = (r_state == S_RUN) ? r_op : c_alu_nop;
    assign alu_wy  = (r_state == S_LOADY);
    assign alu_a   = r_a;
    assign alu_b   = r_b;

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_result = r_resp_result;
    assign bus.resp_err    = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_mesm6_alu_ctl.sv
// ============================================================================
//  Module   : tb_mesm6_alu_ctl
//  Purpose  : Self-checking bench for mesm6_alu_ctl with a behavioural ALU
//             (no reset, clears on ALU_NOP) and a reference model giving
//             expected results and request-to-response latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesm6_alu_ctl;

    localparam int         OPW     = 6;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_AND  = 6'd1;
    localparam logic [5:0] OP_OR   = 6'd2;
    localparam logic [5:0] OP_XOR  = 6'd3;
    localparam logic [5:0] OP_ARX  = 6'd4;
    localparam logic [5:0] OP_YTA  = 6'd5;
    localparam logic [5:0] OP_FADD = 6'd6;
`ifdef MESM6_ALU_TIMEOUT_EN
    localparam int         TMO     = 63;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [OPW-1:0] alu_op;
    logic           alu_wy;
    logic [47:0]    alu_a;
    logic [47:0]    alu_b;
    logic [47:0]    alu_result;
    logic           alu_done;

    mesm6_alu_ctl_if #(.OPW(OPW)) bus ();

    mesm6_alu_ctl #(.OPW(OPW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .alu_op     (alu_op),
        .alu_wy     (alu_wy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic and ALU latency table ----------
    function automatic logic [47:0] alu_fn(input logic [5:0] op, input logic [47:0] a,
                                           input logic [47:0] b, input logic [47:0] y);
        logic [48:0] s;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ARX: begin
                s = {1'b0, a} + {1'b0, b};
                return s[47:0] + {47'd0, s[48]};
            end
            OP_YTA:  return y;
            default: return 48'd0;
        endcase
    endfunction

    // ALU cycles to done; 0 means the ALU never finishes this op
    function automatic int ref_lat(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_YTA: return 1;
            OP_ARX:                        return 2;
            default:                       return 0;
        endcase
    endfunction

    // ---------------- behavioural ALU (environment, no reset) -------------
    logic [47:0] m_y = '0;
    logic [47:0] m_res = '0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (alu_wy) m_y <= alu_a;
        if (alu_op == OP_NOP) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_done && ref_lat(alu_op) != 0) begin
            if (m_cnt + 1 >= ref_lat(alu_op)) begin
                m_done <= 1'b1;
                m_res  <= alu_fn(alu_op, alu_a, alu_b, m_y);
            end
            m_cnt <= m_cnt + 1;
        end
    end
    assign alu_result = m_res;
    assign alu_done   = m_done;

    // ---------------- monitors ---------------------------------------------
    int resp_count = 0;
    int wy_count   = 0;
    always @(posedge clk) begin
        if (bus.resp_valid === 1'b1) resp_count <= resp_count + 1;
        if (alu_wy === 1'b1)         wy_count   <= wy_count + 1;
    end

    // ---------------- checking ---------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_resp = 0;
    logic [47:0] model_y = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and checks its response. Returns at the negedge of
    // the resp_valid cycle so a following call is accepted in the very next
    // IDLE cycle.
    task automatic run_req(input string tag, input logic [5:0] op, input logic wy,
                           input logic [47:0] a, input logic [47:0] b);
        int k;
        logic [47:0] er;
        logic ee;
        int ek;
        ee = 1'b0;
        if (op == OP_NOP) begin
            er = a;
            ek = wy ? 2 : 1;
        end else if (ref_lat(op) == 0) begin
`ifdef MESM6_ALU_TIMEOUT_EN
            er = '0;
            ee = 1'b1;
            ek = TMO + 1;
`else
            er = '0;
            ek = 0;
`endif
        end else begin
            er = alu_fn(op, a, b, model_y);
            ek = ref_lat(op) + 2;
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wy    = wy;
        bus.req_a     = a;
        bus.req_b     = b;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = $urandom_range(0, 63);
        bus.req_a     = {$urandom, $urandom};
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.resp_valid !== 1'b1 && k < 300);
        check({tag, "_latency"}, 64'(k), 64'(ek));
        check({tag, "_result"}, {16'd0, bus.resp_result}, {16'd0, er});
        check({tag, "_err"}, {63'd0, bus.resp_err}, {63'd0, ee});
        check({tag, "_nop_in_resp"}, {58'd0, alu_op}, {58'd0, OP_NOP});
        if (op == OP_NOP && wy) model_y = a;
        exp_resp++;
    endtask

    initial begin
        int k;
        int bad;
        int wy0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_NOP;
        bus.req_wy    = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_result", {16'd0, bus.resp_result}, 64'd0);
        check("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        check("rst_alu_op", {58'd0, alu_op}, 64'd0);
        check("rst_alu_wy", {63'd0, alu_wy}, 64'd0);
        check("rst_alu_ab", {alu_a[31:0], alu_b[31:0]}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {63'd0, bus.req_ready}, 64'd1);

        // Logic op, arithmetic with end-around carry, then back-to-back AND
        run_req("and", OP_AND, 1'b0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F);
        run_req("arx", OP_ARX, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001);
        run_req("and_b2b", OP_AND, 1'b0, 48'h1234_5678_9ABC, 48'hF0F0_F0F0_F0F0);
        check("b2b_resp_count", 64'(resp_count), 64'(exp_resp - 1));
        @(negedge clk);
        check("b2b_pulse_count", 64'(resp_count), 64'(exp_resp));
        check("pulse_one_cycle", {63'd0, bus.resp_valid}, 64'd0);

        // Y load then YTA
        wy0 = wy_count;
        run_req("loady", OP_NOP, 1'b1, 48'h1234_5678_9ABC, 48'd0);
        run_req("yta", OP_YTA, 1'b0, 48'd0, 48'd0);
        check("wy_pulse_count", 64'(wy_count - wy0), 64'd1);
        run_req("nop_echo", OP_NOP, 1'b0, 48'hA5A5_0000_5A5A, 48'd7);
        check("nop_echo_no_wy", 64'(wy_count - wy0), 64'd1);

        // Flush coincident with done: no response, one DRAIN cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ARX;
        bus.req_wy    = 1'b0;
        bus.req_a     = 48'h0000_0000_00FF;
        bus.req_b     = 48'h0000_0000_0001;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (alu_done !== 1'b1 && k < 20);
        check("flush_done_seen", 64'(k), 64'd3);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("drain_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        check("drain_busy", {63'd0, bus.busy}, 64'd1);
        check("drain_alu_nop", {58'd0, alu_op}, 64'd0);
        @(negedge clk);
        check("drain_to_idle", {63'd0, bus.req_ready}, 64'd1);
        check("flush_resp_count", 64'(resp_count), 64'(exp_resp));
        check("flush_result_held", {16'd0, bus.resp_result}, 64'hA5A5_0000_5A5A);
        run_req("or_after_flush", OP_OR, 1'b0, 48'h0000_FFFF_0000, 48'h00F0_0000_000F);

        // Unimplemented op: timeout abort, or indefinite wait until flush
`ifdef MESM6_ALU_TIMEOUT_EN
        run_req("fadd_timeout", OP_FADD, 1'b0, 48'h1, 48'h2);
        run_req("xor_after_tmo", OP_XOR, 1'b0, 48'h0F0F, 48'h00FF);
`else
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FADD;
        bus.req_a     = 48'h1;
        bus.req_b     = 48'h2;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) bad++;
        end
        check("fadd_wait_busy", 64'(bad), 64'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("fadd_drain", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        check("fadd_idle", {63'd0, bus.req_ready}, 64'd1);
        check("fadd_err_const", {63'd0, bus.resp_err}, 64'd0);
`endif

        // Randomized requests against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [5:0] op;
            logic       wy;
            k  = $urandom_range(0, 6);
            wy = 1'b0;
            case (k)
                0: op = OP_AND;
                1: op = OP_OR;
                2: op = OP_XOR;
                3: op = OP_ARX;
                4: op = OP_YTA;
                5: op = OP_NOP;
                default: begin op = OP_NOP; wy = 1'b1; end
            endcase
            run_req($sformatf("rnd%0d", i), op, wy, {$urandom, $urandom}, {$urandom, $urandom});
        end
        @(negedge clk);
        check("rnd_resp_count", 64'(resp_count), 64'(exp_resp));

        // Asynchronous reset mid-RUN
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ARX;
        bus.req_wy    = 1'b0;
        bus.req_a     = 48'hFFFF_FFFF_FFFF;
        bus.req_b     = 48'h0000_0000_0001;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("run_alu_op", {58'd0, alu_op}, {58'd0, OP_ARX});
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_ready", {63'd0, bus.req_ready}, 64'd1);
        check("arst_alu_op", {58'd0, alu_op}, 64'd0);
        check("arst_alu_a", {16'd0, alu_a}, 64'd0);
        check("arst_result", {16'd0, bus.resp_result}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("arst_no_resp", 64'(resp_count), 64'(exp_resp));
        run_req("xor_after_rst", OP_XOR, 1'b0, 48'd5, 48'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mesm6_alu_ctl.md
Name: mesm6_alu_ctl

Overview:
- Sequencer between the instruction-execute unit and the 48-bit ALU (mesm6_alu).
- Accepts one ALU request at a time over a valid/ready handshake and drives the ALU operation and operands.
- Waits for the ALU `done` flag, returns a registered result, and re-arms the ALU with an ALU_NOP cycle.
- Also sequences Y-register loads (UZA/U1A) and aborts in-flight operations on pipeline flush.

Parameters:
- OPW, `ALU_OP_WIDTH: width of ALU operation code.
- TIMEOUT, 63: RUN-state cycle limit before abort (used only with MESM6_ALU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept (high only in IDLE).
- req_op  in  OPW  ALU operation code.
- req_wy  in  1  Y load request; meaningful only with req_op==ALU_NOP.
- req_a  in  48  operand A.
- req_b  in  48  operand B.
- flush  in  1  abort current operation.
- alu_op  out  OPW  to ALU `op`.
- alu_wy  out  1  to ALU `wy`.
- alu_a  out  48  to ALU `a`.
- alu_b  out  48  to ALU `b`.
- alu_result  in  48  from ALU `result`.
- alu_done  in  1  from ALU `done`.
- resp_valid  out  1  one-cycle completion pulse.
- resp_result  out  48  result, held until next resp_valid.
- resp_err  out  1  timeout abort flag, qualified by resp_valid.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset: state=IDLE, alu_op=ALU_NOP, alu_wy=0, alu_a=alu_b=0, resp_valid=0, resp_result=0, resp_err=0, busy=0, req_ready=1 after deassertion.
- The ALU has no reset. Holding ALU_NOP in IDLE clears its count/done on the first edge.
- States: IDLE, LOADY, RUN, RESP, DRAIN.
- IDLE: alu_op=ALU_NOP, alu_wy=0. On req_valid (req_ready=1) the controller latches op/a/b.
  - req_op==ALU_NOP with req_wy=1 -> LOADY.
  - req_op==ALU_NOP with req_wy=0 -> RESP, with resp_result=req_a and no ALU use.
  - Any other op -> RUN.
- LOADY (1 cycle): alu_op=ALU_NOP, alu_wy=1, alu_a=latched a. Then RESP with resp_result=latched a.
- RUN: alu_op=latched op, alu_a/alu_b=latched operands, stable for the whole state.
  - On alu_done=1: capture alu_result into resp_result, resp_err=0 -> RESP.
- RESP (1 cycle): resp_valid=1, alu_op=ALU_NOP (clears ALU done), req_ready=0 -> IDLE.
- DRAIN (1 cycle): alu_op=ALU_NOP, resp_valid=0 -> IDLE.
- Latency: request accepted at edge E0, ALU op needing N cycles -> resp_valid high in the cycle after edge E0+N+1.
  - Logic ops (N=1): 2-cycle latency.
  - ARX/ACX/ANX (N=2): 3-cycle latency.
- Throughput: one request every N+2 cycles; the mandatory ALU_NOP cycle is in RESP.
- flush:
  - In RUN or LOADY -> DRAIN, no response, result discarded.
  - In RUN, flush together with alu_done: flush wins.
  - In LOADY the Y write has already been presented for that cycle and is not undone.
  - Ignored in IDLE and RESP.
  - flush with req_valid in IDLE: request accepted normally.
- resp_result and resp_err hold their values until the next completing response.
- Reset asserted mid-operation: immediate return to reset values, no response for the aborted request.

Optional Feature:
- MESM6_ALU_TIMEOUT_EN defined:
  - A cycle counter (clog2(TIMEOUT+1) bits) clears on RUN entry and increments each RUN cycle without done.
  - Counter reaching TIMEOUT -> RESP with resp_result=0 and resp_err=1. The ALU is cleared by the RESP ALU_NOP cycle.
  - This covers ops the ALU does not implement, e.g. FADD, FMUL.
- Undefined:
  - No counter; resp_err is constant 0.
  - RUN waits indefinitely for alu_done; only flush or reset exits.

Test Plan:
- AND, a=48'hFFFF_0000_FFFF, b=48'h0F0F_0F0F_0F0F -> resp_valid 2 cycles after accept, resp_result=48'h0F0F_0000_0F0F, resp_err=0; alu_op is ALU_NOP in the resp_valid cycle.
- ADD_CARRY_AROUND, a=48'hFFFF_FFFF_FFFF, b=1 -> resp_result=48'h0000_0000_0001 after 3 cycles; a back-to-back AND request is accepted on the first req_ready cycle with no lost or duplicated response.
- LOAD Y: NOP with req_wy=1, a=48'h1234_5678_9ABC; then YTA -> alu_wy pulses exactly 1 cycle; YTA resp_result=48'h1234_5678_9ABC.
- ADD_CARRY_AROUND issued, flush asserted the cycle alu_done=1 -> no resp_valid, one DRAIN cycle with ALU_NOP, next OR request completes correctly.
- With MESM6_ALU_TIMEOUT_EN and TIMEOUT=63: FADD request -> resp_valid with resp_err=1 and resp_result=0 after 63 RUN cycles. Without the macro, busy stays 1 for 200 cycles until flush.
- reset_n low mid-RUN of ADD_CARRY_AROUND -> all outputs reset asynchronously; after release, XOR a=5,b=3 -> resp_result=6, no stale done.
